// File: rtl/decode_stage.sv
// Instruction decode with a single ID/EX slot, load-use and write-back stall detection.
// Optional define DECODE_WB_BYPASS_EN: forward same-cycle write-back data into the operands instead of stalling.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [4:0]  rf_rs,
  output logic [4:0]  rf_rt,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [5:0]  ex_op,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_dest,
  output logic        ex_regwrite,
  output logic        ex_memread
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  slot_state_t state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rs_val_q, rs_val_d;
  logic [31:0] rt_val_q, rt_val_d;
  logic [31:0] imm_q, imm_d;
  logic [5:0]  op_q, op_d;
  logic [5:0]  funct_q, funct_d;
  logic [4:0]  dest_q, dest_d;
  logic        regwrite_q, regwrite_d;
  logic        memread_q, memread_d;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  assign op    = if_instr[31:26];
  assign rs    = if_instr[25:21];
  assign rt    = if_instr[20:16];
  assign rd    = if_instr[15:11];
  assign imm16 = if_instr[15:0];

  assign rf_rs = rs;
  assign rf_rt = rt;

  logic [4:0]  dec_dest;
  logic        dec_regwrite;
  logic        dec_memread;
  logic        uses_rt;
  logic [31:0] dec_imm;

  always_comb begin
    dec_dest     = 5'd0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    uses_rt      = 1'b0;
    case (op)
      OP_RTYPE: begin
        dec_dest     = rd;
        dec_regwrite = 1'b1;
        uses_rt      = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        dec_dest     = rt;
        dec_regwrite = 1'b1;
      end
      OP_LW: begin
        dec_dest     = rt;
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: uses_rt = 1'b1;
      OP_J: ;
      default: ;
    endcase
    // A write to $0 is architecturally a no-op, so never advertise it downstream.
    if (dec_dest == 5'd0) begin
      dec_regwrite = 1'b0;
    end
  end

  always_comb begin
    case (op)
      OP_ANDI, OP_ORI: dec_imm = {16'h0000, imm16};
      OP_LUI:          dec_imm = {imm16, 16'h0000};
      default:         dec_imm = {{16{imm16[15]}}, imm16};
    endcase
  end

  logic slot_full;
  logic ld_hazard;
  logic wb_hazard;
  logic hazard;
  logic accept;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign slot_full = (state_q == S_FULL);

  // Load result is not available until after EX/MEM, so a dependent instruction must wait.
  assign ld_hazard = slot_full & memread_q & (dest_q != 5'd0) &
                     ((dest_q == rs) | (uses_rt & (dest_q == rt)));

`ifdef DECODE_WB_BYPASS_EN
  logic wb_hit_rs;
  logic wb_hit_rt;

  assign wb_hazard = 1'b0;
  assign wb_hit_rs = wb_regwrite & (wb_reg != 5'd0) & (wb_reg == rs);
  assign wb_hit_rt = wb_regwrite & (wb_reg != 5'd0) & (wb_reg == rt);
  assign rs_val    = (rs == 5'd0) ? 32'h0 : (wb_hit_rs ? wb_data : rf_rd1);
  assign rt_val    = (rt == 5'd0) ? 32'h0 : (wb_hit_rt ? wb_data : rf_rd2);
`else
  logic [31:0] unused_wb_data;

  // Without forwarding, the register file read would return stale data this cycle.
  assign wb_hazard      = wb_regwrite & (wb_reg != 5'd0) &
                          ((wb_reg == rs) | (uses_rt & (wb_reg == rt)));
  assign rs_val         = (rs == 5'd0) ? 32'h0 : rf_rd1;
  assign rt_val         = (rt == 5'd0) ? 32'h0 : rf_rd2;
  assign unused_wb_data = wb_data;
`endif

  assign hazard   = ld_hazard | wb_hazard;
  assign id_ready = (~slot_full | ex_ready) & ~hazard & ~flush & ~reset;
  assign accept   = if_valid & id_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rs_val_d   = rs_val_q;
    rt_val_d   = rt_val_q;
    imm_d      = imm_q;
    op_d       = op_q;
    funct_d    = funct_q;
    dest_d     = dest_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      state_d    = S_FULL;
      pc_d       = if_pc;
      rs_val_d   = rs_val;
      rt_val_d   = rt_val;
      imm_d      = dec_imm;
      op_d       = op;
      funct_d    = if_instr[5:0];
      dest_d     = dec_dest;
      regwrite_d = dec_regwrite;
      memread_d  = dec_memread;
    end else begin
      case (state_q)
        S_FULL:  if (ex_ready) state_d = S_EMPTY;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      pc_q       <= 32'h0;
      rs_val_q   <= 32'h0;
      rt_val_q   <= 32'h0;
      imm_q      <= 32'h0;
      op_q       <= 6'h0;
      funct_q    <= 6'h0;
      dest_q     <= 5'h0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rs_val_q   <= rs_val_d;
      rt_val_q   <= rt_val_d;
      imm_q      <= imm_d;
      op_q       <= op_d;
      funct_q    <= funct_d;
      dest_q     <= dest_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
    end
  end

  assign ex_valid    = slot_full;
  assign ex_pc       = pc_q;
  assign ex_rs_val   = rs_val_q;
  assign ex_rt_val   = rt_val_q;
  assign ex_imm      = imm_q;
  assign ex_op       = op_q;
  assign ex_funct    = funct_q;
  assign ex_dest     = dest_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed vectors for accept, stalls, backpressure, flush and reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  rf_rs;
  logic [4:0]  rf_rt;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        wb_regwrite;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic [31:0] ex_imm;
  logic [5:0]  ex_op;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_dest;
  logic        ex_regwrite;
  logic        ex_memread;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_regwrite(wb_regwrite), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val),
    .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_op(ex_op), .ex_funct(ex_funct),
    .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b1; if_instr = 32'h2128FFFC; if_pc = 32'h0000_0100;
    rf_rd1 = 32'h0; rf_rd2 = 32'h0; wb_regwrite = 1'b0; wb_reg = 5'd0; wb_data = 32'h0;
    flush = 1'b0; ex_ready = 1'b1;

    // reset
    settle;
    check("rst_id_ready", 32'(id_ready), 32'd0);
    tick;
    tick;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_regwrite", 32'(ex_regwrite), 32'd0);
    check("rst_memread", 32'(ex_memread), 32'd0);
    check("rst_rs_val", ex_rs_val, 32'h0);
    check("rst_imm", ex_imm, 32'h0);
    check("rst_pc", ex_pc, 32'h0);
    reset = 1'b0; if_valid = 1'b0;
    settle;
    check("post_rst_id_ready", 32'(id_ready), 32'd1);
    tick;

    // addi $8,$9,-4
    if_valid = 1'b1; if_instr = 32'h2128FFFC; if_pc = 32'h0000_0100; rf_rd1 = 32'd5;
    settle;
    check("addi_id_ready", 32'(id_ready), 32'd1);
    check("addi_rf_rs", 32'(rf_rs), 32'd9);
    check("addi_rf_rt", 32'(rf_rt), 32'd8);
    tick;
    check("addi_valid", 32'(ex_valid), 32'd1);
    check("addi_dest", 32'(ex_dest), 32'd8);
    check("addi_regwrite", 32'(ex_regwrite), 32'd1);
    check("addi_imm", ex_imm, 32'hFFFF_FFFC);
    check("addi_rs_val", ex_rs_val, 32'd5);
    check("addi_pc", ex_pc, 32'h0000_0100);
    check("addi_op", 32'(ex_op), 32'h08);

    // lw $8,0($9) followed by dependent add $10,$8,$9
    if_instr = 32'h8D280000; if_pc = 32'h0000_0104; rf_rd1 = 32'h40;
    settle;
    check("lw_id_ready", 32'(id_ready), 32'd1);
    tick;
    check("lw_memread", 32'(ex_memread), 32'd1);
    check("lw_dest", 32'(ex_dest), 32'd8);
    if_instr = 32'h01095020; if_pc = 32'h0000_0108; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    settle;
    check("lu_stall_id_ready", 32'(id_ready), 32'd0);
    tick;
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_after_id_ready", 32'(id_ready), 32'd1);
    tick;
    check("add_valid", 32'(ex_valid), 32'd1);
    check("add_dest", 32'(ex_dest), 32'd10);
    check("add_funct", 32'(ex_funct), 32'h20);
    check("add_rs_val", ex_rs_val, 32'h11);
    check("add_rt_val", ex_rt_val, 32'h22);
    check("add_memread", 32'(ex_memread), 32'd0);

    // backpressure, then flush
    ex_ready = 1'b0; if_instr = 32'h348300F0; if_pc = 32'h0000_010C;
    rf_rd1 = 32'h99; rf_rd2 = 32'h98;
    for (int c = 0; c < 2; c++) begin
      settle;
      check("hold_id_ready", 32'(id_ready), 32'd0);
      tick;
      check("hold_valid", 32'(ex_valid), 32'd1);
      check("hold_dest", 32'(ex_dest), 32'd10);
      check("hold_rs_val", ex_rs_val, 32'h11);
      check("hold_rt_val", ex_rt_val, 32'h22);
      check("hold_pc", ex_pc, 32'h0000_0108);
    end
    flush = 1'b1;
    settle;
    check("flush_id_ready", 32'(id_ready), 32'd0);
    tick;
    check("flush_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; ex_ready = 1'b1;

    // same-cycle write-back to rs=9
    if_instr = 32'h2128FFFC; if_pc = 32'h0000_0200; rf_rd1 = 32'h0;
    wb_regwrite = 1'b1; wb_reg = 5'd9; wb_data = 32'h1234;
`ifdef DECODE_WB_BYPASS_EN
    settle;
    check("wb_id_ready", 32'(id_ready), 32'd1);
    tick;
    check("wb_rs_val", ex_rs_val, 32'h1234);
    check("wb_valid", 32'(ex_valid), 32'd1);
`else
    settle;
    check("wb_stall_id_ready", 32'(id_ready), 32'd0);
    tick;
    check("wb_stall_valid", 32'(ex_valid), 32'd0);
    wb_regwrite = 1'b0; rf_rd1 = 32'h1234;
    settle;
    check("wb_after_id_ready", 32'(id_ready), 32'd1);
    tick;
    check("wb_rs_val", ex_rs_val, 32'h1234);
    check("wb_valid", 32'(ex_valid), 32'd1);
`endif

    // ori $0,$0,0xFFFF with write-back to $0 in flight
    if_instr = 32'h3400FFFF; if_pc = 32'h0000_0204; rf_rd1 = 32'hDEAD; rf_rd2 = 32'h77;
    wb_regwrite = 1'b1; wb_reg = 5'd0; wb_data = 32'h55;
    settle;
    check("zero_id_ready", 32'(id_ready), 32'd1);
    tick;
    check("zero_regwrite", 32'(ex_regwrite), 32'd0);
    check("zero_rs_val", ex_rs_val, 32'h0);
    check("zero_rt_val", ex_rt_val, 32'h0);
    check("zero_imm", ex_imm, 32'h0000_FFFF);
    check("zero_dest", 32'(ex_dest), 32'd0);
    wb_regwrite = 1'b0;

    // lui $1,0xABCD and andi $2,$3,0x8001
    if_instr = 32'h3C01ABCD;
    tick;
    check("lui_imm", ex_imm, 32'hABCD_0000);
    check("lui_dest", 32'(ex_dest), 32'd1);
    check("lui_regwrite", 32'(ex_regwrite), 32'd1);
    if_instr = 32'h30628001;
    tick;
    check("andi_imm", ex_imm, 32'h0000_8001);
    check("andi_dest", 32'(ex_dest), 32'd2);

    // lw $8 then rt-only dependency
    if_instr = 32'h8D280000;
    tick;
    if_instr = 32'h2128FFFC;
    settle;
    check("addi_rt_no_stall", 32'(id_ready), 32'd1);
    if_instr = 32'hAD280000; rf_rd2 = 32'h5A5A;
    settle;
    check("sw_rt_stall", 32'(id_ready), 32'd0);
    tick;
    check("sw_bubble_valid", 32'(ex_valid), 32'd0);
    tick;
    check("sw_valid", 32'(ex_valid), 32'd1);
    check("sw_regwrite", 32'(ex_regwrite), 32'd0);
    check("sw_dest", 32'(ex_dest), 32'd0);
    check("sw_rt_val", ex_rt_val, 32'h5A5A);

    // unknown opcode 0x3F
    if_instr = 32'hFD280000; if_pc = 32'h0000_0300;
    tick;
    check("unk_dest", 32'(ex_dest), 32'd0);
    check("unk_regwrite", 32'(ex_regwrite), 32'd0);
    check("unk_memread", 32'(ex_memread), 32'd0);
    check("unk_pc", ex_pc, 32'h0000_0300);

    // reset while holding
    ex_ready = 1'b0; if_instr = 32'h2128FFFC;
    tick;
    check("pre_rst_hold_valid", 32'(ex_valid), 32'd1);
    reset = 1'b1;
    settle;
    check("rst_hold_id_ready", 32'(id_ready), 32'd0);
    tick;
    check("rst_hold_valid", 32'(ex_valid), 32'd0);
    check("rst_hold_rt_val", ex_rt_val, 32'h0);
    check("rst_hold_pc", ex_pc, 32'h0);
    reset = 1'b0; if_valid = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
